// File: rtl/glb_load_ctrl.sv
// Tile load controller upstream of the GLB: LOAD rows, SETTLE, DRAIN the burst, FLUSH the skew, DONE.
// Optional stall counter on stall_cnt_o is enabled by defining GLB_LOAD_PERF_EN.
module glb_load_ctrl #(
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int PE_SIZE         = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] in_data_i,
    output logic                               glb_wren_o,
    output logic [FIFO_DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o,
    output logic                               glb_rden_o,
    input  logic [PE_SIZE-1:0]                 glb_full_i,
    input  logic [PE_SIZE-1:0]                 glb_empty_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [15:0]                        stall_cnt_o
);

    localparam int RW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(PE_SIZE) + 1;
    localparam int DW = FIFO_DATA_WIDTH * PE_SIZE;

    typedef enum logic [2:0] {
        IDLE, LOAD, SETTLE, DRAIN, FLUSH, DONE
    } state_e;

    state_e          state_q;
    logic [RW-1:0]   row_cnt_q;
    logic [PW-1:0]   phase_cnt_q;
    logic            wren_q;
    logic [DW-1:0]   wdata_q;
    logic            rden_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic            handshake;

    // Only lane 0 is drained directly; the GLB skews the remaining lanes itself.
    logic unused_empty;
    assign unused_empty = ^glb_empty_i[PE_SIZE-1:1];

    assign in_ready_o = (state_q == LOAD) && !(|glb_full_i);
    assign handshake  = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            phase_cnt_q <= '0;
            wren_q      <= 1'b0;
            // NOTE: the write-data register is reset too, so glb_wdata_o is a known 0 after reset.
            wdata_q     <= '0;
            rden_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the pre-edge values.
            wren_q <= handshake;
            if (handshake) begin
                wdata_q <= in_data_i;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= LOAD;
                        row_cnt_q <= '0;
                        err_q     <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        if (row_cnt_q == RW'(FIFO_DEPTH - 1)) begin
                            state_q   <= SETTLE;
                            row_cnt_q <= '0;
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end
                SETTLE: begin
                    // Last write lands this cycle; the read burst starts only after it.
                    state_q   <= DRAIN;
                    row_cnt_q <= '0;
                    rden_q    <= 1'b1;
                end
                DRAIN: begin
                    if (glb_empty_i[0]) begin
                        err_q <= 1'b1;
                    end
                    if (row_cnt_q == RW'(FIFO_DEPTH - 1)) begin
                        state_q     <= FLUSH;
                        rden_q      <= 1'b0;
                        phase_cnt_q <= '0;
                    end else begin
                        row_cnt_q <= row_cnt_q + RW'(1);
                    end
                end
                FLUSH: begin
                    // PE_SIZE-1 skew cycles plus one cycle of FIFO read latency.
                    if (phase_cnt_q == PW'(PE_SIZE - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        phase_cnt_q <= phase_cnt_q + PW'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign glb_wren_o  = wren_q;
    assign glb_wdata_o = wdata_q;
    assign glb_rden_o  = rden_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

`ifdef GLB_LOAD_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            stall_cnt_q <= '0;
        end else if (in_ready_o && !in_valid_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    assign stall_cnt_o = 16'd0;
`endif

endmodule
